mem_block_ctrl: RTL
===================

Name: mem_block_ctrl

Overview:
- Initiator side of the outside-memory interface: issues word-by-word addresses, write enables and instruction/data select to the memory, and collects its combinational read data.
- Sits between a cache and the memory model.
- Turns a single cache request into a block fill (BLOCK_WORDS reads) or a block write-back (BLOCK_WORDS writes).
- Reports completion with a one-cycle done pulse.

Parameters:
- DATA_WIDTH, 32, word width; must match the memory word.
- ADDR_WIDTH, 64, byte-address width.
- BLOCK_WORDS, 16, words per block; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- arst  in  1  asynchronous reset, active-high.
- i_start  in  1  request strobe; sampled only in IDLE.
- i_write  in  1  request type: 1 = write-back, 0 = fill.
- i_access  in  1  memory select for fills: 0 = instruction, 1 = data.
- i_addr  in  ADDR_WIDTH  any byte address inside the target block.
- i_wblock  in  BLOCK_WORDS*DATA_WIDTH  write-back data; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_rblock  out  BLOCK_WORDS*DATA_WIDTH  block buffer; same word packing as i_wblock.
- o_busy  out  1  high while in FILL or WBACK.
- o_done  out  1  one-cycle completion pulse.
- o_mem_addr  out  ADDR_WIDTH  byte address to memory.
- o_mem_write_en  out  1  memory write enable.
- o_mem_access  out  1  memory select to memory.
- o_mem_data  out  DATA_WIDTH  write data to memory.
- i_mem_data  in  DATA_WIDTH  combinational read data from memory.

Behaviour:
- Reset values (arst high, asynchronous):
  - State goes to IDLE.
  - Word counter, buffer and o_rblock are 0.
  - o_busy, o_done, o_mem_write_en, o_mem_access are 0.
  - o_mem_addr and o_mem_data are 0.
- Reset asserted mid-operation aborts immediately; no further write-enable cycles occur.
- States: IDLE, FILL, WBACK, DONE.
- IDLE, on i_start:
  - Latch base = i_addr with the low log2(BLOCK_WORDS)+2 bits cleared.
  - Latch access, and clear counter cnt to 0.
  - i_write=0: go to FILL.
  - i_write=1: load buffer from i_wblock, go to WBACK.
- i_start outside IDLE is ignored; the request is not queued.
- FILL, per cycle:
  - o_mem_addr = base + cnt*4; o_mem_access = latched access; o_mem_write_en = 0.
  - Capture i_mem_data into buffer word cnt at the rising edge.
  - When cnt == BLOCK_WORDS-1, go to DONE; otherwise cnt+1.
- WBACK, per cycle:
  - o_mem_addr = base + cnt*4; o_mem_data = buffer word cnt; o_mem_write_en = 1.
  - o_mem_access forced to 1, because only data memory is writable; latched access is ignored.
  - Same counting and exit rule as FILL.
- DONE: o_done = 1 for exactly one cycle, then IDLE.
- Latency: i_start at cycle 0 → BLOCK_WORDS memory cycles (1..BLOCK_WORDS) → o_done at cycle BLOCK_WORDS+1. Next i_start is accepted at cycle BLOCK_WORDS+2.
- o_rblock mirrors the buffer. It is stable and valid when o_done is high, and holds until the next accepted request. After a write-back it equals the written data.
- Address arithmetic: offset is cnt*4 added to an aligned base, so it never carries out of the block; the low 2 address bits are always 0.
- In IDLE and DONE:
  - o_mem_write_en = 0.
  - o_mem_addr holds its last value.
  - o_mem_access holds its last value.
- o_mem_write_en is never high outside WBACK.

Optional Feature:
- Macro: MEM_BLOCK_CTRL_CRIT_FIRST_EN.
- Defined: fills are critical-word-first.
  - Start index = i_addr word offset (bits [log2(BLOCK_WORDS)+1:2]). Word index = (start + cnt) mod BLOCK_WORDS, wrapping within the block.
  - Adds output o_crit_valid (1 bit): one-cycle pulse in the cycle after the requested word is captured (cycle 2 after i_start).
  - Write-backs are unchanged and always start at word 0.
- Undefined: fills always start at word 0, and o_crit_valid does not exist.

Test Plan:
- Fill, BLOCK_WORDS=16, i_addr=0x4C, i_access=1, memory word n = 0xA000_0000+n → o_mem_addr steps 0x40..0x7C, one per cycle. o_done at cycle 17. o_rblock word k = 0xA000_0010+k.
- Write-back, i_addr=0x100, i_wblock word k = 0x5500+k, i_access=0 → write_en high for exactly 16 cycles with o_mem_access=1. Memory words 64..79 = 0x5500..0x550F. Then read-back fill returns the same values.
- i_start held high continuously → requests accepted only at cycles 0, 18, 36. No write_en glitch in DONE or IDLE.
- arst pulsed at cycle 5 of a write-back → o_mem_write_en=0 and o_busy=0 immediately. Memory words 5..15 of the block are unmodified. Idle state is restored.
- Instruction fill, i_addr=0xF8, i_access=0 → o_mem_access=0 and addresses 0xC0..0xFC. No address beyond 0xFC is driven.
- With MEM_BLOCK_CTRL_CRIT_FIRST_EN, fill i_addr=0x74 → address order 0x74,0x78,0x7C,0x40..0x70. o_crit_valid at cycle 2. Final o_rblock identical to the non-feature build.

Source files
------------

// File: rtl/mem_block_ctrl.sv
// Block-transfer initiator between a cache and word-wide memory: one request becomes a
// block fill or write-back. Optional macro MEM_BLOCK_CTRL_CRIT_FIRST_EN: critical-word-first fills.
module mem_block_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                              clk,
  input  logic                              arst,
  input  logic                              i_start,
  input  logic                              i_write,
  input  logic                              i_access,
  input  logic [ADDR_WIDTH-1:0]             i_addr,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] i_wblock,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] o_rblock,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [ADDR_WIDTH-1:0]             o_mem_addr,
  output logic                              o_mem_write_en,
  output logic                              o_mem_access,
  output logic [DATA_WIDTH-1:0]             o_mem_data,
`ifdef MEM_BLOCK_CTRL_CRIT_FIRST_EN
  output logic                              o_crit_valid,
`endif
  input  logic [DATA_WIDTH-1:0]             i_mem_data
);

  localparam int WB = $clog2(BLOCK_WORDS);
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'(BLOCK_WORDS * 4 - 1);

  typedef enum logic [1:0] {IDLE, FILL, WBACK, DONE} state_t;

  state_t                state;
  logic [WB-1:0]         cnt;
  logic [WB-1:0]         widx;
  logic [WB-1:0]         widx_nxt;
  logic [WB-1:0]         entry_idx;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] req_base;
  logic                  last;

  always_comb begin
    req_base = i_addr & ~OFFS_MASK;
    widx_nxt = widx + WB'(1);
    last     = (cnt == WB'(BLOCK_WORDS - 1));
`ifdef MEM_BLOCK_CTRL_CRIT_FIRST_EN
    entry_idx = i_write ? '0 : i_addr[WB+1:2];
`else
    entry_idx = '0;
`endif
  end

  // Outputs are registered, so the first address/data of a transfer is loaded on the
  // accepting edge and each later one is loaded one edge ahead of its memory cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state          <= IDLE;
      cnt            <= '0;
      widx           <= '0;
      base           <= '0;
      o_rblock       <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_write_en <= 1'b0;
      o_mem_access   <= 1'b0;
      o_mem_data     <= '0;
`ifdef MEM_BLOCK_CTRL_CRIT_FIRST_EN
      o_crit_valid   <= 1'b0;
`endif
    end else begin
`ifdef MEM_BLOCK_CTRL_CRIT_FIRST_EN
      o_crit_valid <= (state == FILL) && (cnt == '0);
`endif
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            base       <= req_base;
            cnt        <= '0;
            widx       <= entry_idx;
            o_mem_addr <= req_base + ADDR_WIDTH'({entry_idx, 2'b00});
            o_busy     <= 1'b1;
            if (i_write) begin
              o_rblock       <= i_wblock;
              o_mem_data     <= i_wblock[0 +: DATA_WIDTH];
              o_mem_write_en <= 1'b1;
              o_mem_access   <= 1'b1;
              state          <= WBACK;
            end else begin
              o_mem_access <= i_access;
              state        <= FILL;
            end
          end
        end
        FILL: begin
          o_rblock[int'(widx) * DATA_WIDTH +: DATA_WIDTH] <= i_mem_data;
          if (last) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            cnt        <= cnt + WB'(1);
            widx       <= widx_nxt;
            o_mem_addr <= base + ADDR_WIDTH'({widx_nxt, 2'b00});
          end
        end
        WBACK: begin
          if (last) begin
            o_mem_write_en <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b1;
            state          <= DONE;
          end else begin
            cnt        <= cnt + WB'(1);
            widx       <= widx_nxt;
            o_mem_addr <= base + ADDR_WIDTH'({widx_nxt, 2'b00});
            o_mem_data <= o_rblock[int'(widx_nxt) * DATA_WIDTH +: DATA_WIDTH];
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
